spi_slave_loader: RTL and testbench
===================================

// Module: spi_slave_loader
// PURPOSE
// - Board-side SPI master that drives the PULPino SPI-slave port (spi_cs_i / spi_sdi0_i) in standard single-bit mode.
// - Converts 32-bit word-write requests into SPI write-memory transactions:
//   command 8'h02, then 32-bit address, then 32-bit data, MSB first.
// - Loads program/data memory from on-board logic; no host PC required.
// PARAMETERS
// - CLK_DIV    default 4      SCK half-period in clk cycles; legal range 1..255
// - CMD_WRITE  default 8'h02  command byte sent first in every transaction
// - CS_GAP     default 4      clk cycles csn_o stays high between transactions; legal range 1..255
// PORTS
// - clk          in   1   clock
// - rst_n        in   1   reset, asynchronous, active-low
// - req_valid_i  in   1   write request valid
// - req_ready_o  out  1   request accepted when req_valid_i && req_ready_o on a rising clk edge
// - req_addr_i   in   32  target byte address, word aligned
// - req_data_i   in   32  word to write
// - busy_o       out  1   high from the accept cycle until GAP completes
// - done_o       out  1   one-cycle pulse in the cycle csn_o rises
// - spi_sck_o    out  1   SPI clock, idle low (mode 0)
// - spi_csn_o    out  1   chip select, active-low
// - spi_sdo_o    out  1   serial data to the slave's sdi0
// BEHAVIOUR
// - Reset values: req_ready_o=1, busy_o=0, done_o=0, spi_sck_o=0, spi_csn_o=1, spi_sdo_o=0.
//   State=IDLE; the shift register and counters clear.
// - FSM states IDLE -> SETUP -> SHIFT -> GAP -> IDLE.
//   All outputs are registered except req_ready_o, which equals (state==IDLE).
// - IDLE
//   - On accept, latch {CMD_WRITE, req_addr_i, req_data_i} into a 72-bit shift register and go to SETUP.
//   - The next cycle: csn_o=0 and sdo_o=bit71.
// - SETUP
//   - Hold sck_o=0 for CLK_DIV cycles, then go to SHIFT.
// - SHIFT
//   - Each bit is sck_o high for CLK_DIV cycles, then low for CLK_DIV cycles.
//   - sdo_o updates to the next bit in the same cycle sck_o falls (mode 0; the slave samples on the rising edge).
//   - A 7-bit counter tracks bits 0..71.
//   - After the low phase of bit 72, go to GAP.
// - GAP
//   - csn_o=1, sdo_o=0, done_o pulses in the first GAP cycle.
//   - Hold for CS_GAP cycles, then go to IDLE; busy_o falls with it.
// - Timing
//   - csn_o is low for exactly (1 + 2*72)*CLK_DIV = 145*CLK_DIV cycles.
//   - Exactly 72 rising SCK edges per transaction.
// - Boundaries
//   - req_valid_i while busy is ignored; the requester must hold it until accepted.
//   - Back-to-back requests: the next accept occurs in the first IDLE cycle after GAP.
//   - An asynchronous reset mid-transaction forces reset values immediately; the partial frame is abandoned.
//   - CLK_DIV=1: sck_o toggles every clk cycle.
// CONFIGURATION
// - Macro SPI_LOADER_BURST_EN.
// - Defined:
//   - In the last low-phase cycle of a frame's final data bit, req_ready_o is also high.
//   - If req_valid_i && req_addr_i == last_addr+4 in that cycle:
//     - latch req_data_i into bits [71:40];
//     - keep csn_o low and continue SHIFT for 32 more bits (no command or address);
//     - track last_addr.
//   - A non-sequential or absent request ends the frame normally.
//   - done_o pulses once per frame, not once per word.
// - Undefined:
//   - Every request produces a full 72-bit frame.
//   - No burst logic or last_addr register is synthesised.
// TESTING
// - Reset check: assert rst_n=0 mid-SHIFT
//   -> same-cycle csn_o=1, sck_o=0, sdo_o=0, req_ready_o=1 after release.
// - Single write, CLK_DIV=2: addr=32'h0010_0000, data=32'hDEAD_BEEF
//   -> csn_o low exactly 290 cycles, 72 SCK rises;
//   -> the slave model captures 8'h02, 32'h0010_0000, 32'hDEAD_BEEF;
//   -> done_o is a 1-cycle pulse.
// - Two back-to-back requests, CS_GAP=4
//   -> csn_o high exactly 4 cycles between frames;
//   -> second request accepted on the first IDLE cycle; both words captured.
// - req_valid_i toggled while busy
//   -> no acceptance, frame bits unchanged; the held request is accepted after GAP.
// - CLK_DIV=1, data=32'h0000_0001
//   -> sck_o toggles every cycle, frame captured correctly, LSB=1 on the final rising edge.
// - BURST_EN: requests at addr 0x100, 0x104, 0x108, then 0x200
//   -> frame 1 is 136 bits (cmd+addr+3 words) under one csn_o low;
//   -> 0x200 starts a new 72-bit frame; two done_o pulses.

Source files
------------

// File: rtl/spi_slave_loader.sv
// SPI master that turns 32-bit word writes into SPI write-memory frames (cmd, addr, data).
// Define SPI_LOADER_BURST_EN to chain sequential-address words into one chip-select frame.
`timescale 1ns/1ps
module spi_slave_loader #(
    parameter int unsigned CLK_DIV   = 4,
    parameter logic [7:0]  CMD_WRITE = 8'h02,
    parameter int unsigned CS_GAP    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_data_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        spi_sck_o,
    output logic        spi_csn_o,
    output logic        spi_sdo_o
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_GAP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    // The IDLE accept cycle is the last high cycle of chip select, so GAP is one shorter.
    localparam logic [7:0] GAP_LAST = (CS_GAP > 1) ? 8'(CS_GAP - 2) : 8'd0;
    localparam logic [6:0] LAST_BIT = 7'd71;

    state_t      state_q, state_d;
    logic [71:0] sr_q, sr_d;
    logic [7:0]  div_q, div_d;
    logic [6:0]  bit_q, bit_d;
    logic [7:0]  gap_q, gap_d;
    logic        sck_q, sck_d;
    logic        csn_q, csn_d;
    logic        sdo_q, sdo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        frame_end;
    logic        burst_take;

    assign frame_end = (state_q == S_SHIFT) && !sck_q && (div_q == DIV_LAST) && (bit_q == LAST_BIT);

`ifdef SPI_LOADER_BURST_EN
    logic [31:0] last_addr_q, last_addr_d;
    logic        addr_seq;

    assign addr_seq   = (req_addr_i == last_addr_q + 32'd4);
    // Ready is only offered in the chaining window for a sequential address, so a
    // handshake there always means the word joins the current frame.
    assign burst_take  = frame_end && req_valid_i && addr_seq;
    assign req_ready_o = (state_q == S_IDLE) || (frame_end && addr_seq);
`else
    assign burst_take  = 1'b0;
    assign req_ready_o = (state_q == S_IDLE);
`endif

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        div_d   = div_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        sck_d   = sck_q;
        csn_d   = csn_q;
        sdo_d   = sdo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef SPI_LOADER_BURST_EN
        last_addr_d = last_addr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    state_d = S_SETUP;
                    sr_d    = {CMD_WRITE, req_addr_i, req_data_i};
                    sdo_d   = CMD_WRITE[7];
                    csn_d   = 1'b0;
                    busy_d  = 1'b1;
                    div_d   = 8'd0;
                    bit_d   = 7'd0;
`ifdef SPI_LOADER_BURST_EN
                    last_addr_d = req_addr_i;
`endif
                end
            end
            S_SETUP: begin
                if (div_q == DIV_LAST) begin
                    state_d = S_SHIFT;
                    sck_d   = 1'b1;
                    div_d   = 8'd0;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            S_SHIFT: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + 8'd1;
                end else if (sck_q) begin
                    // Falling edge: present the next bit for the following rising edge.
                    div_d = 8'd0;
                    sck_d = 1'b0;
                    sr_d  = {sr_q[70:0], 1'b0};
                    sdo_d = sr_q[70];
                end else if (!frame_end) begin
                    div_d = 8'd0;
                    sck_d = 1'b1;
                    bit_d = bit_q + 7'd1;
                end else if (burst_take) begin
                    // Re-run a setup phase so the new word's MSB settles before the next rise.
                    state_d = S_SETUP;
                    div_d   = 8'd0;
                    sr_d    = {req_data_i, 40'd0};
                    sdo_d   = req_data_i[31];
                    bit_d   = 7'd40;
`ifdef SPI_LOADER_BURST_EN
                    last_addr_d = req_addr_i;
`endif
                end else begin
                    div_d  = 8'd0;
                    csn_d  = 1'b1;
                    sdo_d  = 1'b0;
                    done_d = 1'b1;
                    sr_d   = 72'd0;
                    bit_d  = 7'd0;
                    gap_d  = 8'd0;
                    if (CS_GAP > 1) begin
                        state_d = S_GAP;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    gap_d   = 8'd0;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sr_q    <= 72'd0;
            div_q   <= 8'd0;
            bit_q   <= 7'd0;
            gap_q   <= 8'd0;
            sck_q   <= 1'b0;
            csn_q   <= 1'b1;
            sdo_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SPI_LOADER_BURST_EN
            last_addr_q <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            sck_q   <= sck_d;
            csn_q   <= csn_d;
            sdo_q   <= sdo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SPI_LOADER_BURST_EN
            last_addr_q <= last_addr_d;
`endif
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign spi_sck_o = sck_q;
    assign spi_csn_o = csn_q;
    assign spi_sdo_o = sdo_q;

endmodule

// File: tb/tb_spi_slave_loader.sv
// Bench for spi_slave_loader: two instances (CLK_DIV=2 and CLK_DIV=1) watched by an SPI slave model.
`timescale 1ns/1ps
module tb_spi_slave_loader;

    typedef struct {
        int           nbits;
        logic [135:0] bits;
        int           low;
        int           rises;
        int           hb;
    } frame_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        valid = 2'b00;
    logic [1:0][31:0]  addr = '0;
    logic [1:0][31:0]  data = '0;
    wire  [1:0]        ready, busy, done, sck, csn, sdo;

    int checks = 0;
    int passes = 0;

    frame_t       frames0[$];
    frame_t       frames1[$];
    int           low_cnt[2], rises[2], nb[2], high_cnt[2], hb[2];
    int           done_cnt[2], done_bad[2], tog_bad[2], exp_done[2];
    logic [135:0] acc[2];
    logic [1:0]   sck_prev = 2'b00, csn_prev = 2'b11, done_prev = 2'b00, seen = 2'b00, last_bit = 2'b00;

    always #5 clk = ~clk;

    spi_slave_loader #(.CLK_DIV(2), .CMD_WRITE(8'h02), .CS_GAP(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid_i(valid[0]), .req_ready_o(ready[0]),
        .req_addr_i(addr[0]), .req_data_i(data[0]), .busy_o(busy[0]), .done_o(done[0]),
        .spi_sck_o(sck[0]), .spi_csn_o(csn[0]), .spi_sdo_o(sdo[0]));

    spi_slave_loader #(.CLK_DIV(1), .CMD_WRITE(8'h02), .CS_GAP(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid_i(valid[1]), .req_ready_o(ready[1]),
        .req_addr_i(addr[1]), .req_data_i(data[1]), .busy_o(busy[1]), .done_o(done[1]),
        .spi_sck_o(sck[1]), .spi_csn_o(csn[1]), .spi_sdo_o(sdo[1]));

    initial begin
        for (int i = 0; i < 2; i++) begin
            low_cnt[i] = 0; rises[i] = 0; nb[i] = 0; high_cnt[i] = 0; hb[i] = 0;
            done_cnt[i] = 0; done_bad[i] = 0; tog_bad[i] = 0; exp_done[i] = 0; acc[i] = '0;
        end
    end

    // Slave model: samples the bus mid-cycle and captures sdo on every sck rise under csn low.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                low_cnt[i] = 0; rises[i] = 0; nb[i] = 0; acc[i] = '0;
                high_cnt[i] = 0; seen[i] = 1'b0;
            end else begin
                if (done[i]) begin
                    done_cnt[i]++;
                    if (done_prev[i] || !(csn[i] && !csn_prev[i])) done_bad[i]++;
                end
                if (!csn[i]) begin
                    if (csn_prev[i]) begin
                        hb[i] = high_cnt[i]; low_cnt[i] = 0; rises[i] = 0;
                        nb[i] = 0; acc[i] = '0; seen[i] = 1'b0;
                    end
                    low_cnt[i]++;
                    if (sck[i] && !sck_prev[i]) begin
                        rises[i]++; nb[i]++;
                        acc[i] = {acc[i][134:0], sdo[i]};
                        last_bit[i] = sdo[i];
                    end
                    if (seen[i] && !csn_prev[i] && (sck[i] == sck_prev[i])) tog_bad[i]++;
                    if (sck[i]) seen[i] = 1'b1;
                end else begin
                    if (!csn_prev[i]) begin
                        frame_t f;
                        f.nbits = nb[i]; f.bits = acc[i]; f.low = low_cnt[i];
                        f.rises = rises[i]; f.hb = hb[i];
                        if (i == 0) frames0.push_back(f); else frames1.push_back(f);
                        high_cnt[i] = 0;
                    end
                    high_cnt[i]++;
                end
            end
            sck_prev[i] = sck[i]; csn_prev[i] = csn[i]; done_prev[i] = done[i];
        end
    end

    task automatic chk(input string tag, input logic [135:0] got, input logic [135:0] exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    endtask

    function automatic logic [135:0] frame72(input logic [31:0] a, input logic [31:0] d);
        return {64'd0, 8'h02, a, d};
    endfunction

    function automatic int qsize(input int i);
        return (i == 0) ? frames0.size() : frames1.size();
    endfunction

    task automatic req(input int i, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        valid[i] = 1'b1; addr[i] = a; data[i] = d;
        do begin
            @(negedge clk);
            n++;
        end while (!ready[i] && n < 5000);
        if (!ready[i]) chk($sformatf("accept_timeout%0d", i), ready[i], 1'b1);
        @(posedge clk);
        #1;
        valid[i] = 1'b0;
        $display("req inst=%0d addr=%08h data=%08h accepted at %0t", i, a, d, $time);
    endtask

    task automatic wait_frames(input int i, input int n);
        int c = 0;
        while (qsize(i) < n && c < 5000) begin
            @(posedge clk);
            c++;
        end
        chk($sformatf("frame_wait%0d", i), qsize(i) >= n, 1'b1);
        #1;
    endtask

    task automatic check_frame(input int i, input int exp_nbits, input logic [135:0] exp_bits,
                               input int exp_low, input int exp_hb);
        frame_t f;
        if (qsize(i) == 0) return;
        if (i == 0) f = frames0.pop_front(); else f = frames1.pop_front();
        chk($sformatf("nbits%0d", i), f.nbits, exp_nbits);
        chk($sformatf("bits%0d", i), f.bits, exp_bits);
        chk($sformatf("sck_rises%0d", i), f.rises, exp_nbits);
        if (exp_low > 0) chk($sformatf("csn_low_cycles%0d", i), f.low, exp_low);
        if (exp_hb >= 0) chk($sformatf("csn_high_gap%0d", i), f.hb, exp_hb);
        exp_done[i]++;
        $display("frame inst=%0d bits=%0d low=%0d data=%0h", i, f.nbits, f.low, f.bits);
    endtask

    initial begin
        logic [31:0] a, d, a2, d2;
        int hits;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", ready[0], 1'b1);
        chk("rst_busy", busy[0], 1'b0);
        chk("rst_done", done[0], 1'b0);
        chk("rst_sck", sck[0], 1'b0);
        chk("rst_csn", csn[0], 1'b1);
        chk("rst_sdo", sdo[0], 1'b0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single write, CLK_DIV=2
        req(0, 32'h0010_0000, 32'hDEAD_BEEF);
        chk("busy_after_accept", busy[0], 1'b1);
        chk("csn_after_accept", csn[0], 1'b0);
        chk("sdo_first_bit", sdo[0], 1'b0);
        wait_frames(0, 1);
        check_frame(0, 72, frame72(32'h0010_0000, 32'hDEAD_BEEF), 290, -1);
        repeat (6) @(posedge clk);
        #1;
        chk("busy_after_gap", busy[0], 1'b0);
        chk("ready_after_gap", ready[0], 1'b1);
        chk("done_pulses_single", done_cnt[0], exp_done[0]);

        // Back-to-back requests
        a = {$urandom, 2'b00}; d = $urandom;
        a2 = {$urandom, 2'b00}; d2 = $urandom;
        req(0, a, d);
        req(0, a2, d2);
        wait_frames(0, 2);
        check_frame(0, 72, frame72(a, d), 290, -1);
        check_frame(0, 72, frame72(a2, d2), 290, 4);

        // Request toggled while busy must be ignored
        a = {$urandom, 2'b00}; d = $urandom;
        a2 = {$urandom, 2'b00}; d2 = $urandom;
        req(0, a, d);
        hits = 0;
        for (int k = 0; k < 40; k++) begin
            valid[0] = 1'($urandom_range(0, 1));
            addr[0] = $urandom | 32'h1;
            data[0] = $urandom;
            @(negedge clk);
            if (ready[0]) hits++;
            @(posedge clk);
            #1;
        end
        valid[0] = 1'b0;
        chk("no_accept_while_busy", hits, 0);
        req(0, a2, d2);
        wait_frames(0, 2);
        check_frame(0, 72, frame72(a, d), 290, -1);
        check_frame(0, 72, frame72(a2, d2), 290, 4);

        // Asynchronous reset mid-SHIFT abandons the frame
        repeat (10) @(posedge clk);
        #1;
        req(0, {$urandom, 2'b00}, $urandom);
        repeat (30) @(posedge clk);
        #2;
        chk("csn_before_reset", csn[0], 1'b0);
        rst_n = 1'b0;
        #1;
        chk("reset_csn", csn[0], 1'b1);
        chk("reset_sck", sck[0], 1'b0);
        chk("reset_sdo", sdo[0], 1'b0);
        chk("reset_busy", busy[0], 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", ready[0], 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk("no_partial_frame", qsize(0), 0);

        // CLK_DIV=1, data LSB set
        a = {$urandom, 2'b00};
        req(1, a, 32'h0000_0001);
        wait_frames(1, 1);
        check_frame(1, 72, frame72(a, 32'h0000_0001), 145, -1);
        chk("clkdiv1_last_bit", last_bit[1], 1'b1);
        chk("clkdiv1_toggle", tog_bad[1], 0);

        // Randomized writes on both instances
        for (int k = 0; k < 3; k++) begin
            a = {$urandom, 2'b00}; d = $urandom;
            req(0, a, d);
            wait_frames(0, 1);
            check_frame(0, 72, frame72(a, d), 290, -1);
            a = {$urandom, 2'b00}; d = $urandom;
            req(1, a, d);
            wait_frames(1, 1);
            check_frame(1, 72, frame72(a, d), 145, -1);
        end

`ifdef SPI_LOADER_BURST_EN
        begin
            logic [31:0] w1, w2, w3, w4;
            w1 = $urandom; w2 = $urandom; w3 = $urandom; w4 = $urandom;
            repeat (8) @(posedge clk);
            #1;
            req(0, 32'h0000_0100, w1);
            req(0, 32'h0000_0104, w2);
            req(0, 32'h0000_0108, w3);
            req(0, 32'h0000_0200, w4);
            wait_frames(0, 2);
            check_frame(0, 136, {8'h02, 32'h0000_0100, w1, w2, w3}, 0, -1);
            check_frame(0, 72, frame72(32'h0000_0200, w4), 290, 4);
        end
`endif

        repeat (10) @(posedge clk);
        #1;
        chk("done_count0", done_cnt[0], exp_done[0]);
        chk("done_count1", done_cnt[1], exp_done[1]);
        chk("done_shape0", done_bad[0], 0);
        chk("done_shape1", done_bad[1], 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
